serial_word_deserializer: RTL and testbench

Upstream feeder for the N-bit load register. Collects a framed serial bit stream into an N-bit word and, once a full word is assembled, presents it on `dout` with a one-cycle `load` pulse. `dout`/`load` connect directly to the register's `din`/`load`. Handles frame resync on a new start marker and flags bits dropped during the load cycle.

---
 rtl/deser_pkg.sv | 20 ++
 rtl/shift_reg_in.sv | 58 +++++
 rtl/serial_word_deserializer.sv | 131 +++++++++++++
 tb/tb_serial_word_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_pkg
// Description : Shared types and limits for the serial word deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    // Widest word the deserializer may be built for.
    localparam int DESER_MAX_N = 32;

    // Frame-assembly states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } deser_state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_in.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_in
// Description : N-bit serial-in shift register with synchronous clear.
//               Exposes its next-state value so the owner can capture the
//               completed word on the same edge as the final bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_in #(
    parameter int N         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         clear,
    input  logic         bit_in,
    output logic [N-1:0] q_next
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_shifted;

    // Shifted value; with clear set, the old contents are replaced by zeros
    // so the incoming bit becomes the first bit of a fresh word.
    if (N == 1) begin : g_single
        assign w_shifted = bit_in;
    end else if (MSB_FIRST != 0) begin : g_msb
        logic [N-1:0] w_base;
        assign w_base    = clear ? '0 : r_q;
        assign w_shifted = {w_base[N-2:0], bit_in};
    end else begin : g_lsb
        logic [N-1:0] w_base;
        assign w_base    = clear ? '0 : r_q;
        assign w_shifted = {bit_in, w_base[N-1:1]};
    end

    // Select the register's next contents: shift, clear or hold.
    always_comb begin
        q_next = r_q;
        if (shift_en) begin
            q_next = w_shifted;
        end else if (clear) begin
            q_next = '0;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= q_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer
// Description : Assembles a framed serial bit stream into N-bit words and
//               presents each completed word with a one-cycle load pulse.
//               Resyncs on a new start marker; flags bits dropped in LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int N         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sin_valid,
    input  logic         sin_bit,
    input  logic         sin_start,
    output logic [N-1:0] dout,
    output logic         load,
    output logic         busy,
    output logic         overrun
);

    localparam int             CW  = $clog2(N + 1);
    localparam logic [CW-1:0]  c_N = CW'(N);

    if (N < 1 || N > DESER_MAX_N) begin : g_bad_n
        $error("serial_word_deserializer: N out of range");
    end

    deser_state_t  r_state;
    deser_state_t  w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic          w_shift;
    logic          w_clear;
    logic          w_drop;
    logic [N-1:0]  w_word_next;
    logic [N-1:0]  r_dout;
    logic          r_overrun;

    assign w_cnt_inc = r_cnt + 1'b1;

    shift_reg_in #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg_in (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_shift),
        .clear    (w_clear),
        .bit_in   (sin_bit),
        .q_next   (w_word_next)
    );

    // Next-state, counter and datapath-control decode.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                // Only a start-marked bit opens a frame; others are ignored.
                if (sin_valid && sin_start) begin
                    w_shift      = 1'b1;
                    w_clear      = 1'b1;
                    w_cnt_next   = CW'(1);
                    w_next_state = (N == 1) ? LOAD : SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    w_shift = 1'b1;
                    if (sin_start) begin
                        // Resync: drop the partial word, this bit is bit 1.
                        w_clear      = 1'b1;
                        w_cnt_next   = CW'(1);
                        w_next_state = (N == 1) ? LOAD : SHIFT;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == c_N) begin
                            w_next_state = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                // Any bit offered while presenting the word is lost.
                w_next_state = IDLE;
                w_cnt_next   = '0;
                w_drop       = sin_valid;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, counter, output word and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            // Capture the completed word on the edge that enters LOAD.
            if (w_next_state == LOAD) begin
                r_dout <= w_word_next;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout    = r_dout;
    assign load    = (r_state == LOAD);
    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_deserializer
// Description : Self-checking bench; three deserializer builds share one
//               input stream and are compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_deserializer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sin_valid = 1'b0;
    logic sin_bit = 1'b0;
    logic sin_start = 1'b0;

    logic [3:0] dout_m, dout_l;
    logic [0:0] dout_1;
    logic load_m, load_l, load_1;
    logic busy_m, busy_l, busy_1;
    logic ovr_m, ovr_l, ovr_1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.N(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_start(sin_start), .dout(dout_m), .load(load_m), .busy(busy_m),
        .overrun(ovr_m));
    serial_word_deserializer #(.N(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_start(sin_start), .dout(dout_l), .load(load_l), .busy(busy_l),
        .overrun(ovr_l));
    serial_word_deserializer #(.N(1), .MSB_FIRST(1)) dut_1 (
        .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_start(sin_start), .dout(dout_1), .load(load_1), .busy(busy_1),
        .overrun(ovr_1));

    // Actual outputs gathered per build for the random sweep.
    logic [31:0] a_dout [NI];
    logic        a_load [NI];
    logic        a_busy [NI];
    logic        a_ovr  [NI];
    always_comb begin
        a_dout[0] = 32'(dout_m); a_load[0] = load_m; a_busy[0] = busy_m; a_ovr[0] = ovr_m;
        a_dout[1] = 32'(dout_l); a_load[1] = load_l; a_busy[1] = busy_l; a_ovr[1] = ovr_l;
        a_dout[2] = 32'(dout_1); a_load[2] = load_1; a_busy[2] = busy_1; a_ovr[2] = ovr_1;
    end

    // Frame-level model: received bits kept in arrival order.
    int          mn   [NI] = '{4, 4, 1};
    int          mmsb [NI] = '{1, 0, 1};
    bit          mb   [NI][32];
    int          mc   [NI] = '{0, 0, 0};
    bit          mld  [NI] = '{0, 0, 0};
    bit [31:0]   mdout[NI] = '{0, 0, 0};
    bit          movr [NI] = '{0, 0, 0};

    function automatic bit [31:0] word_of(int k);
        bit [31:0] w = '0;
        for (int i = 0; i < mn[k]; i++) begin
            if (mmsb[k] != 0) w[mn[k] - 1 - i] = mb[k][i];
            else              w[i]            = mb[k][i];
        end
        return w;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                mc[k] = 0; mld[k] = 0; mdout[k] = '0; movr[k] = 0;
            end else if (mld[k]) begin
                mld[k] = 0;
                if (sin_valid) movr[k] = 1;
            end else if (sin_valid && (sin_start || mc[k] > 0)) begin
                if (sin_start) mc[k] = 0;
                mb[k][mc[k]] = sin_bit;
                mc[k]++;
                if (mc[k] == mn[k]) begin
                    mdout[k] = word_of(k);
                    mld[k]   = 1;
                    mc[k]    = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic b);
        reset = r; sin_valid = v; sin_start = s; sin_bit = b;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        total++; if (dout_m !== 4'b0000) begin bad++; $display("FAIL reset_dout got=%b want=0000", dout_m); end
        total++; if (load_m !== 1'b0 || load_l !== 1'b0 || load_1 !== 1'b0) begin bad++; $display("FAIL reset_load got=%b%b%b want=000", load_m, load_l, load_1); end
        total++; if (busy_m !== 1'b0 || busy_l !== 1'b0 || busy_1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b%b want=000", busy_m, busy_l, busy_1); end
        total++; if (ovr_m !== 1'b0 || ovr_l !== 1'b0 || ovr_1 !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b%b%b want=000", ovr_m, ovr_l, ovr_1); end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise got=%b want=1", busy_m); end
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        total++; if (load_m !== 1'b0) begin bad++; $display("FAIL b2b_early_load got=%b want=0", load_m); end
        step(0, 1, 0, 1);
        total++; if (load_m !== 1'b1) begin bad++; $display("FAIL b2b_load got=%b want=1", load_m); end
        total++; if (dout_m !== 4'b1011) begin bad++; $display("FAIL b2b_dout_msb got=%b want=1011", dout_m); end
        total++; if (dout_l !== 4'b1101) begin bad++; $display("FAIL b2b_dout_lsb got=%b want=1101", dout_l); end
        total++; if (ovr_m !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", ovr_m); end
        step(0, 0, 0, 0);
        total++; if (load_m !== 1'b0 || busy_m !== 1'b0) begin bad++; $display("FAIL b2b_after got=load%b busy%b want=load0 busy0", load_m, busy_m); end
        total++; if (dout_m !== 4'b1011) begin bad++; $display("FAIL b2b_dout_hold got=%b want=1011", dout_m); end
    endtask

    task automatic test_gapped();
        logic [3:0] pat;
        int loads;
        pat = 4'b0110;
        loads = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i == 0), pat[3 - i]);
            total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL gap_busy bit=%0d got=%b want=1", i, busy_m); end
            if (load_m === 1'b1) loads++;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    step(0, 0, 0, 0);
                    total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL gap_busy_idle bit=%0d got=%b want=1", i, busy_m); end
                    if (load_m === 1'b1) loads++;
                end
            end
        end
        total++; if (dout_m !== 4'b0110) begin bad++; $display("FAIL gap_dout got=%b want=0110", dout_m); end
        for (int g = 0; g < 2; g++) begin
            step(0, 0, 0, 0);
            if (load_m === 1'b1) loads++;
        end
        total++; if (loads != 1) begin bad++; $display("FAIL gap_load_count got=%0d want=1", loads); end
    endtask

    task automatic test_resync();
        logic [5:0] bits;
        logic [5:0] starts;
        int loads;
        bits   = 6'b110010;
        starts = 6'b101000;
        loads  = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, starts[5 - i], bits[5 - i]);
            if (load_m === 1'b1) loads++;
        end
        for (int g = 0; g < 2; g++) begin
            step(0, 0, 0, 0);
            if (load_m === 1'b1) loads++;
        end
        total++; if (dout_m !== 4'b0010) begin bad++; $display("FAIL resync_dout_msb got=%b want=0010", dout_m); end
        total++; if (dout_l !== 4'b0100) begin bad++; $display("FAIL resync_dout_lsb got=%b want=0100", dout_l); end
        total++; if (loads != 1) begin bad++; $display("FAIL resync_load_count got=%0d want=1", loads); end
    endtask

    task automatic test_overrun();
        step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        total++; if (ovr_m !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b want=0", ovr_m); end
        // Offer a start-marked bit during LOAD: it must be dropped.
        step(0, 1, 1, 0);
        total++; if (ovr_m !== 1'b1 || ovr_l !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b%b want=11", ovr_m, ovr_l); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL ovr_dropped_start got=busy%b want=busy0", busy_m); end
        total++; if (dout_m !== 4'b1111) begin bad++; $display("FAIL ovr_dout got=%b want=1111", dout_m); end
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        total++; if (dout_m !== 4'b0101) begin bad++; $display("FAIL ovr_next_frame got=%b want=0101", dout_m); end
        total++; if (ovr_m !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ovr_m); end
        step(1, 0, 0, 0);
        total++; if (ovr_m !== 1'b0) begin bad++; $display("FAIL ovr_reset got=%b want=0", ovr_m); end
    endtask

    task automatic test_reset_mid();
        int loads;
        loads = 0;
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        total++; if (busy_m !== 1'b0 || load_m !== 1'b0) begin bad++; $display("FAIL mid_reset got=busy%b load%b want=busy0 load0", busy_m, load_m); end
        total++; if (dout_m !== 4'b0000 || dout_l !== 4'b0000) begin bad++; $display("FAIL mid_dout got=%b/%b want=0000/0000", dout_m, dout_l); end
        step(0, 1, 0, 1);
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL mid_nonstart got=busy%b want=busy0", busy_m); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
            if (load_m === 1'b1) loads++;
        end
        total++; if (loads != 0) begin bad++; $display("FAIL mid_no_load got=%0d want=0", loads); end
    endtask

    task automatic test_random();
        logic r, v, s, b;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 6);
            s = v && ($urandom_range(0, 6) == 0);
            b = 1'($urandom);
            step(r, v, s, b);
            for (int k = 0; k < NI; k++) begin
                total++; if (a_dout[k] !== mdout[k]) begin bad++; $display("FAIL rnd_dout cyc=%0d dut=%0d got=%h want=%h", n, k, a_dout[k], mdout[k]); end
                total++; if (a_load[k] !== mld[k]) begin bad++; $display("FAIL rnd_load cyc=%0d dut=%0d got=%b want=%b", n, k, a_load[k], mld[k]); end
                total++; if (a_busy[k] !== (mld[k] || mc[k] > 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d dut=%0d got=%b want=%b", n, k, a_busy[k], (mld[k] || mc[k] > 0)); end
                total++; if (a_ovr[k] !== movr[k]) begin bad++; $display("FAIL rnd_overrun cyc=%0d dut=%0d got=%b want=%b", n, k, a_ovr[k], movr[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_resync();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
